xoodyak_host_if: RTL

Host-side driver for the XOODYAK hash core's byte interface. It buffers a message written by a host, streams it to the core over load/msg with msg_len, then pulses start. It then collects the 32 returned hash bytes into a 256-bit digest. Sits between a host bus/CPU shim and XOODYAK, on the opposite end of the core's load/start/hash/valid protocol from the core itself.

---
 rtl/xoodyak_host_if_if.sv | 35 +++
 rtl/xoodyak_host_if.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/xoodyak_host_if_if.sv
// Host and core signal bundle for the XOODYAK host-side driver.
// The slave modport is the driver. The master modport is the host/core side (the testbench).
interface xoodyak_host_if_if #(
  parameter int LEN_W = 12
);
  logic             wr_en;
  logic [7:0]       wr_data;
  logic [5:0]       buf_count;
  logic             buf_full;
  logic             overflow;
  logic             go;
  logic             busy;
  logic             load;
  logic [7:0]       msg;
  logic [LEN_W-1:0] msg_len;
  logic             start;
  logic [7:0]       hash;
  logic             valid;
  logic [255:0]     digest;
  logic             digest_valid;
  logic             timeout_err;
  logic             empty_err;

  modport slave (
    input  wr_en, wr_data, go, hash, valid,
    output buf_count, buf_full, overflow, busy, load, msg, msg_len, start,
           digest, digest_valid, timeout_err, empty_err
  );

  modport master (
    output wr_en, wr_data, go, hash, valid,
    input  buf_count, buf_full, overflow, busy, load, msg, msg_len, start,
           digest, digest_valid, timeout_err, empty_err
  );
endinterface

// File: rtl/xoodyak_host_if.sv
// Host-side driver for the XOODYAK byte interface: it buffers a message and streams it to the core.
// It then pulses start and collects the returned hash bytes into a 256-bit digest.
//
// state     | meaning
// S_IDLE    | accept host writes and go
// S_LOAD    | drive buffered bytes on msg with load high
// S_GAP     | idle cycles before the start pulse
// S_START   | start pulse, arm the timeout timer
// S_COLLECT | shift in hash bytes until complete or timed out
module xoodyak_host_if #(
  parameter int MAX_MSG_BYTES = 32,
  parameter int LEN_W         = 12,
  parameter int DIGEST_BYTES  = 32,
  parameter int START_GAP     = 5,
  parameter int TIMEOUT       = 4095
) (
  input  logic                 clk,
  input  logic                 resetn,
  xoodyak_host_if_if.slave     bus
);

  localparam int ADDR_W = $clog2(MAX_MSG_BYTES);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int DB_W   = $clog2(DIGEST_BYTES + 1);
  localparam int GAP_W  = $clog2(START_GAP + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_START,
    S_COLLECT
  } state_t;

  state_t             r_state;
  logic [7:0]         r_mem [MAX_MSG_BYTES];
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_idx;
  logic [GAP_W-1:0]   r_gap;
  logic [TMO_W-1:0]   r_tmo;
  logic [DB_W-1:0]    r_bcnt;
  logic               r_overflow;
  logic               r_load;
  logic [7:0]         r_msg;
  logic [LEN_W-1:0]   r_msg_len;
  logic               r_start;
  logic [255:0]       r_digest;
  logic               r_dvalid;
  logic               r_timeout_err;
  logic               r_empty_err;

  logic w_idle;
  logic w_full;
  logic w_go_ok;
  logic w_wr_ok;
  logic w_wr_drop;

  assign w_idle    = (r_state == S_IDLE);
  assign w_full    = (r_count == CNT_W'(MAX_MSG_BYTES));
  assign w_go_ok   = w_idle && bus.go && (r_count != '0);
  // An accepted go takes the cycle; a write arriving with it is not buffered.
  assign w_wr_ok   = w_idle && bus.wr_en && !w_full && !w_go_ok;
  assign w_wr_drop = w_idle && bus.wr_en && w_full && !w_go_ok;

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_count[ADDR_W-1:0]] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_idx         <= '0;
      r_gap         <= '0;
      r_tmo         <= '0;
      r_bcnt        <= '0;
      r_overflow    <= 1'b0;
      r_load        <= 1'b0;
      r_msg         <= '0;
      r_msg_len     <= '0;
      r_start       <= 1'b0;
      r_digest      <= '0;
      r_dvalid      <= 1'b0;
      r_timeout_err <= 1'b0;
      r_empty_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_dvalid <= 1'b0;
          if (w_wr_ok)   r_count    <= r_count + CNT_W'(1);
          if (w_wr_drop) r_overflow <= 1'b1;
          if (bus.go && r_count == '0) r_empty_err <= 1'b1;
          if (w_go_ok) begin
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_empty_err   <= 1'b0;
            r_digest      <= '0;
            r_msg_len     <= LEN_W'(r_count) - LEN_W'(1);
            r_load        <= 1'b1;
            r_msg         <= r_mem[0];
            r_idx         <= CNT_W'(1);
            r_state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (r_idx == r_count) begin
            r_load  <= 1'b0;
            r_msg   <= '0;
            r_count <= '0;
            r_gap   <= GAP_W'(START_GAP - 1);
            r_state <= S_GAP;
          end else begin
            r_msg <= r_mem[r_idx[ADDR_W-1:0]];
            r_idx <= r_idx + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (r_gap == '0) begin
            r_start <= 1'b1;
            r_state <= S_START;
          end else begin
            r_gap <= r_gap - GAP_W'(1);
          end
        end
        S_START: begin
          r_start <= 1'b0;
          r_tmo   <= TMO_W'(TIMEOUT - 1);
          r_bcnt  <= '0;
          r_state <= S_COLLECT;
        end
        S_COLLECT: begin
          if (bus.valid) begin
            r_digest <= {r_digest[247:0], bus.hash};
            r_bcnt   <= r_bcnt + DB_W'(1);
          end
          // A final byte arriving on the terminal cycle still completes the digest.
          if (bus.valid && r_bcnt == DB_W'(DIGEST_BYTES - 1)) begin
            r_dvalid <= 1'b1;
            r_state  <= S_IDLE;
          end else if (r_tmo == '0) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_tmo <= r_tmo - TMO_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.buf_count    = r_count;
  assign bus.buf_full     = w_full;
  assign bus.overflow     = r_overflow;
  assign bus.busy         = !w_idle;
  assign bus.load         = r_load;
  assign bus.msg          = r_msg;
  assign bus.msg_len      = r_msg_len;
  assign bus.start        = r_start;
  assign bus.digest       = r_digest;
  assign bus.digest_valid = r_dvalid;
  assign bus.timeout_err  = r_timeout_err;
  assign bus.empty_err    = r_empty_err;

endmodule
